// File: rtl/decode_stage_hz_pkg.sv
// Shared pipeline definitions: opcodes, instruction classes, decode FSM encoding
// and the opcode-to-class helper used by decode and, later, by the EX/MEM hazard logic.
package pipe_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] LW    = 6'd1;
    localparam logic [OPC_W-1:0] SW    = 6'd2;
    localparam logic [OPC_W-1:0] ADD   = 6'd3;
    localparam logic [OPC_W-1:0] SUB   = 6'd4;
    localparam logic [OPC_W-1:0] AND   = 6'd5;
    localparam logic [OPC_W-1:0] OR    = 6'd6;
    localparam logic [OPC_W-1:0] MUL   = 6'd7;
    localparam logic [OPC_W-1:0] SLT   = 6'd8;
    localparam logic [OPC_W-1:0] ADDI  = 6'd9;
    localparam logic [OPC_W-1:0] SUBI  = 6'd10;
    localparam logic [OPC_W-1:0] SLTI  = 6'd11;
    localparam logic [OPC_W-1:0] BEQZ  = 6'd12;
    localparam logic [OPC_W-1:0] BNEQZ = 6'd13;
    localparam logic [OPC_W-1:0] HLT   = 6'd63;

    localparam logic [2:0] TY_RR_ALU = 3'd0;
    localparam logic [2:0] TY_RI_ALU = 3'd1;
    localparam logic [2:0] TY_LOAD   = 3'd2;
    localparam logic [2:0] TY_STORE  = 3'd3;
    localparam logic [2:0] TY_BRANCH = 3'd4;
    localparam logic [2:0] TY_HALT   = 3'd5;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    typedef enum logic [1:0] {
        DSEL_NONE = 2'd0,
        DSEL_RT   = 2'd1,
        DSEL_RD   = 2'd2
    } dest_sel_e;

    typedef struct packed {
        logic [2:0] ty;
        dest_sel_e  dsel;
        logic       uses_rs;
        logic       uses_rt;
    } op_class_t;

    // Unknown opcodes fall into the halt class so a corrupted fetch stops the core.
    function automatic op_class_t classify_op(input logic [OPC_W-1:0] op);
        op_class_t c;
        c = '{TY_HALT, DSEL_NONE, 1'b0, 1'b0};
        case (op)
            ADD, SUB, AND, OR, SLT, MUL: c = '{TY_RR_ALU, DSEL_RD,   1'b1, 1'b1};
            ADDI, SUBI, SLTI:            c = '{TY_RI_ALU, DSEL_RT,   1'b1, 1'b0};
            LW:                          c = '{TY_LOAD,   DSEL_RT,   1'b1, 1'b0};
            SW:                          c = '{TY_STORE,  DSEL_NONE, 1'b1, 1'b1};
            BEQZ, BNEQZ:                 c = '{TY_BRANCH, DSEL_NONE, 1'b1, 1'b0};
            default:                     ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_hz_if.sv
// IF/ID -> ID/EX decode bus: instruction in, register-file read/write-back, ID/EX registers out.
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_hz_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              halt_f;
    logic              flush;
    logic [DATA_W-1:0] ins_i;
    logic [DATA_W-1:0] npc_i;
    logic              valid_i;
    logic [REG_AW-1:0] rs_addr_o;
    logic [REG_AW-1:0] rt_addr_o;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wb_wren;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall_o;
    logic [DATA_W-1:0] ins_o;
    logic [DATA_W-1:0] npc_o;
    logic [DATA_W-1:0] imm_o;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic [2:0]        type_o;
    logic [REG_AW-1:0] dest_o;
    logic              valid_o;

    modport master (
        output halt_f, flush, ins_i, npc_i, valid_i,
        output rs_data, rt_data, wb_wren, wb_addr, wb_data,
        input  rs_addr_o, rt_addr_o, stall_o,
        input  ins_o, npc_o, imm_o, a_o, b_o, type_o, dest_o, valid_o
    );

    modport slave (
        input  halt_f, flush, ins_i, npc_i, valid_i,
        input  rs_data, rt_data, wb_wren, wb_addr, wb_data,
        output rs_addr_o, rt_addr_o, stall_o,
        output ins_o, npc_o, imm_o, a_o, b_o, type_o, dest_o, valid_o
    );

endinterface

// File: rtl/decode_stage_hz_classify.sv
// Combinational instruction classifier: class, destination register and source usage.
module decode_classify
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [DATA_W-1:0] ins_i,
    output logic [2:0]        type_o,
    output logic [REG_AW-1:0] dest_o,
    output logic              uses_rs_o,
    output logic              uses_rt_o
);

    localparam int OPC_LSB = DATA_W - OPC_W;
    localparam int RS_LSB  = OPC_LSB - REG_AW;
    localparam int RT_LSB  = RS_LSB - REG_AW;
    localparam int RD_LSB  = RT_LSB - REG_AW;

    op_class_t cls;
    logic      unused_low;

    assign cls        = classify_op(ins_i[DATA_W-1 -: OPC_W]);
    assign unused_low = ^{ins_i[RD_LSB-1:0], ins_i[RS_LSB +: REG_AW]};

    assign type_o    = cls.ty;
    assign uses_rs_o = cls.uses_rs;
    assign uses_rt_o = cls.uses_rt;

    always_comb begin
        dest_o = '0;
        case (cls.dsel)
            DSEL_RT: dest_o = ins_i[RT_LSB +: REG_AW];
            DSEL_RD: dest_o = ins_i[RD_LSB +: REG_AW];
            default: dest_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS32 ID stage: decodes IF/ID into ID/EX with write-back bypass, load-use bubble,
// flush and a sticky HALTED state entered on a halt-class instruction.
//   state  | meaning
//   RUN    | normal decode; bubbles only on load-use hazards
//   HALTED | HLT issued; IF/ID held, bubbles until flush or rst
module decode_stage_hz
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input logic         clk,
    input logic         rst,
    decode_stage_hz_if.slave dif
);

    localparam int OPC_LSB = DATA_W - OPC_W;
    localparam int RS_LSB  = OPC_LSB - REG_AW;
    localparam int RT_LSB  = RS_LSB - REG_AW;

    logic [REG_AW-1:0] rs_f;
    logic [REG_AW-1:0] rt_f;
    logic [2:0]        cls_type;
    logic [REG_AW-1:0] cls_dest;
    logic              cls_uses_rs;
    logic              cls_uses_rt;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;

    logic [DATA_W-1:0] ins_q,   ins_d;
    logic [DATA_W-1:0] npc_q,   npc_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [DATA_W-1:0] a_q,     a_d;
    logic [DATA_W-1:0] b_q,     b_d;
    logic [2:0]        type_q,  type_d;
    logic [REG_AW-1:0] dest_q,  dest_d;
    logic              valid_q, valid_d;
    logic [0:0]        state_q, state_d;

    assign rs_f = dif.ins_i[RS_LSB +: REG_AW];
    assign rt_f = dif.ins_i[RT_LSB +: REG_AW];

    decode_classify #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_classify (
        .ins_i     (dif.ins_i),
        .type_o    (cls_type),
        .dest_o    (cls_dest),
        .uses_rs_o (cls_uses_rs),
        .uses_rt_o (cls_uses_rt)
    );

    // r0 reads as zero and is never bypassed, even if write-back targets it.
    always_comb begin
        opa = dif.rs_data;
        if (rs_f == '0) begin
            opa = '0;
        end else if (dif.wb_wren && (dif.wb_addr == rs_f)) begin
            opa = dif.wb_data;
        end
    end

    always_comb begin
        opb = dif.rt_data;
        if (rt_f == '0) begin
            opb = '0;
        end else if (dif.wb_wren && (dif.wb_addr == rt_f)) begin
            opb = dif.wb_data;
        end
    end

    assign imm_ext = {{(DATA_W-IMM_W){dif.ins_i[IMM_W-1]}}, dif.ins_i[IMM_W-1:0]};

    // Only sources the incoming opcode actually reads can collide with the load in EX.
    assign hazard = dif.valid_i && valid_q && (type_q == TY_LOAD) && (dest_q != '0) &&
                    ((cls_uses_rs && (rs_f == dest_q)) || (cls_uses_rt && (rt_f == dest_q)));

    assign dif.stall_o = (hazard && (state_q == ST_RUN) && !dif.halt_f) ||
                         (state_q == ST_HALTED);

    always_comb begin
        ins_d   = ins_q;
        npc_d   = npc_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        type_d  = type_q;
        dest_d  = dest_q;
        valid_d = valid_q;
        state_d = state_q;
        if (dif.halt_f) begin
            state_d = state_q;
        end else if (dif.flush) begin
            valid_d = 1'b0;
            dest_d  = '0;
            state_d = ST_RUN;
        end else if ((state_q == ST_HALTED) || hazard) begin
            valid_d = 1'b0;
            dest_d  = '0;
        end else begin
            ins_d   = dif.ins_i;
            npc_d   = dif.npc_i;
            imm_d   = imm_ext;
            a_d     = opa;
            b_d     = opb;
            type_d  = cls_type;
            valid_d = dif.valid_i;
            dest_d  = dif.valid_i ? cls_dest : '0;
            if (dif.valid_i && (cls_type == TY_HALT)) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_q   <= '0;
            npc_q   <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            type_q  <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            ins_q   <= ins_d;
            npc_q   <= npc_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            type_q  <= type_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign dif.rs_addr_o = rs_f;
    assign dif.rt_addr_o = rt_f;
    assign dif.ins_o     = ins_q;
    assign dif.npc_o     = npc_q;
    assign dif.imm_o     = imm_q;
    assign dif.a_o       = a_q;
    assign dif.b_o       = b_q;
    assign dif.type_o    = type_q;
    assign dif.dest_o    = dest_q;
    assign dif.valid_o   = valid_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: directed vector table, async-reset/halt sequence,
// then random traffic against a behavioural model of the decode rules.
module tb_decode_stage_hz;
    import pipe_pkg::*;

    typedef struct {
        logic        halt_f, flush, valid, wren;
        logic [31:0] ins, npc, rs_data, rt_data, wb_data;
        logic [4:0]  wb_addr;
    } in_t;

    typedef struct {
        in_t         in;
        logic        stall;
        logic [31:0] a, b, imm;
        logic [2:0]  ty;
        logic [4:0]  dest;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] ins, npc, imm, a, b;
        logic [2:0]  ty;
        logic [4:0]  dest;
        logic        valid;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_hz_if #(.DATA_W(32), .REG_AW(5)) dif ();

    decode_stage_hz #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int   checks = 0;
    int   errors = 0;
    out_t m;
    bit   m_halted;
    vec_t tv[24];
    in_t  rx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic in_t mk_in(logic [31:0] ins, logic [31:0] rsd, logic [31:0] rtd,
                                  int hf, int fl, int vi, int we, int wa, logic [31:0] wd);
        in_t x;
        x.ins = ins; x.npc = ins ^ 32'h0000_1000; x.rs_data = rsd; x.rt_data = rtd;
        x.halt_f = (hf != 0); x.flush = (fl != 0); x.valid = (vi != 0);
        x.wren = (we != 0); x.wb_addr = 5'(wa); x.wb_data = wd;
        return x;
    endfunction

    function automatic vec_t mkv(in_t x, int st, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                 int ty, int dest, int v);
        vec_t r;
        r.in = x; r.stall = (st != 0); r.a = a; r.b = b; r.imm = imm;
        r.ty = 3'(ty); r.dest = 5'(dest); r.valid = (v != 0);
        return r;
    endfunction

    task automatic drive(input in_t x);
        dif.ins_i   = x.ins;     dif.npc_i   = x.npc;     dif.valid_i = x.valid;
        dif.rs_data = x.rs_data; dif.rt_data = x.rt_data;
        dif.wb_wren = x.wren;    dif.wb_addr = x.wb_addr; dif.wb_data = x.wb_data;
        dif.halt_f  = x.halt_f;  dif.flush   = x.flush;
    endtask

    // Reference model: instruction classes straight from the opcode list.
    task automatic classify(input logic [5:0] op, output logic [2:0] ty, output bit urs,
                            output bit urt, output int dk);
        ty = 3'd5; urs = 0; urt = 0; dk = 0;
        if (op inside {ADD, SUB, AND, OR, SLT, MUL}) begin ty = 3'd0; urs = 1; urt = 1; dk = 2; end
        else if (op inside {ADDI, SUBI, SLTI})       begin ty = 3'd1; urs = 1; dk = 1; end
        else if (op == LW)                           begin ty = 3'd2; urs = 1; dk = 1; end
        else if (op == SW)                           begin ty = 3'd3; urs = 1; urt = 1; end
        else if (op inside {BEQZ, BNEQZ})            begin ty = 3'd4; urs = 1; end
    endtask

    function automatic logic [31:0] operand(in_t x, logic [4:0] r, logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (x.wren && x.wb_addr == r) return x.wb_data;
        return rf;
    endfunction

    task automatic model_comb(input in_t x, output bit hz, output bit st);
        logic [2:0] ty; bit urs, urt; int dk;
        classify(x.ins[31:26], ty, urs, urt, dk);
        hz = x.valid && m.valid && m.ty == 3'd2 && m.dest != 5'd0 &&
             ((urs && x.ins[25:21] == m.dest) || (urt && x.ins[20:16] == m.dest));
        st = m_halted || (hz && !x.halt_f);
    endtask

    task automatic model_update(input in_t x, input bit hz);
        logic [2:0] ty; bit urs, urt; int dk;
        classify(x.ins[31:26], ty, urs, urt, dk);
        if (x.halt_f) begin
        end else if (x.flush) begin
            m.valid = 0; m.dest = 0; m_halted = 0;
        end else if (m_halted || hz) begin
            m.valid = 0; m.dest = 0;
        end else begin
            m.ins = x.ins; m.npc = x.npc; m.ty = ty; m.valid = x.valid;
            m.imm = {{16{x.ins[15]}}, x.ins[15:0]};
            m.a = operand(x, x.ins[25:21], x.rs_data);
            m.b = operand(x, x.ins[20:16], x.rt_data);
            m.dest = !x.valid ? 5'd0 : (dk == 1) ? x.ins[20:16] : (dk == 2) ? x.ins[15:11] : 5'd0;
            if (x.valid && ty == 3'd5) m_halted = 1;
        end
    endtask

    task automatic model_reset();
        m.ins = 0; m.npc = 0; m.imm = 0; m.a = 0; m.b = 0; m.ty = 0; m.dest = 0; m.valid = 0;
        m_halted = 0;
    endtask

    task automatic step_model(input in_t x);
        bit hz, st;
        @(negedge clk);
        drive(x);
        #1;
        model_comb(x, hz, st);
        chk("stall_o", 32'(dif.stall_o), 32'(st));
        chk("rs_addr_o", 32'(dif.rs_addr_o), 32'(x.ins[25:21]));
        chk("rt_addr_o", 32'(dif.rt_addr_o), 32'(x.ins[20:16]));
        @(posedge clk);
        model_update(x, hz);
        #1;
        chk("ins_o", dif.ins_o, m.ins);
        chk("npc_o", dif.npc_o, m.npc);
        chk("imm_o", dif.imm_o, m.imm);
        chk("a_o", dif.a_o, m.a);
        chk("b_o", dif.b_o, m.b);
        chk("type_o", 32'(dif.type_o), 32'(m.ty));
        chk("dest_o", 32'(dif.dest_o), 32'(m.dest));
        chk("valid_o", 32'(dif.valid_o), 32'(m.valid));
    endtask

    function automatic logic [5:0] op_pick(int k);
        case (k)
            0: return LW;    1: return SW;    2: return ADD;   3: return SUB;
            4: return AND;   5: return OR;    6: return MUL;   7: return SLT;
            8: return ADDI;  9: return SUBI;  10: return SLTI; 11: return BEQZ;
            default: return BNEQZ;
        endcase
    endfunction

    function automatic in_t rand_in();
        in_t x;
        logic [5:0]  op;
        logic [15:0] low;
        if ($urandom_range(0, 99) < 4)
            op = ($urandom_range(0, 1) == 1) ? HLT : 6'($urandom_range(14, 62));
        else
            op = op_pick(int'($urandom_range(0, 12)));
        low = ($urandom_range(0, 1) == 1) ? 16'($urandom) : {5'($urandom_range(0, 3)), 11'($urandom)};
        x.ins     = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), low};
        x.npc     = $urandom;
        x.rs_data = $urandom;
        x.rt_data = $urandom;
        x.valid   = ($urandom_range(0, 99) < 85);
        x.halt_f  = ($urandom_range(0, 99) < 10);
        x.flush   = ($urandom_range(0, 99) < 8);
        x.wren    = ($urandom_range(0, 1) == 1);
        x.wb_addr = 5'($urandom_range(0, 3));
        x.wb_data = $urandom;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t add_in, hlt_in;
        add_in = mk_in(enc_r(ADD, 5'd1, 5'd2, 5'd3), 32'd5, 32'd7, 0, 0, 1, 0, 0, 32'd0);
        hlt_in = mk_in(enc_r(HLT, 5'd0, 5'd0, 5'd0), 32'd1, 32'd2, 0, 0, 1, 0, 0, 32'd0);

        tv[0]  = mkv(add_in, 0, 32'd5, 32'd7, 32'h1800, 0, 3, 1);
        tv[1]  = mkv(mk_in(enc_i(ADDI, 5'd1, 5'd4, 16'hFFFE), 32'h99, 32'h55, 0, 0, 1, 1, 1, 32'h10),
                     0, 32'h10, 32'h55, 32'hFFFF_FFFE, 1, 4, 1);
        tv[2]  = mkv(mk_in(enc_i(LW, 5'd1, 5'd2, 16'd0), 32'h100, 32'h22, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'h100, 32'h22, 32'd0, 2, 2, 1);
        tv[3]  = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'h33, 32'h44, 0, 0, 1, 0, 0, 32'd0),
                     1, 32'h100, 32'h22, 32'd0, 2, 0, 0);
        tv[4]  = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'h77, 32'h44, 0, 0, 1, 1, 2, 32'hAA),
                     0, 32'hAA, 32'h44, 32'h2800, 0, 5, 1);
        tv[5]  = mkv(mk_in(enc_i(LW, 5'd1, 5'd2, 16'd4), 32'h10, 32'd0, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'h10, 32'd0, 32'd4, 2, 2, 1);
        tv[6]  = mkv(mk_in(enc_i(SW, 5'd6, 5'd7, 16'd8), 32'h66, 32'h88, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'h66, 32'h88, 32'd8, 3, 0, 1);
        tv[7]  = mkv(mk_in(enc_i(LW, 5'd1, 5'd0, 16'd0), 32'h11, 32'h99, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'h11, 32'd0, 32'd0, 2, 0, 1);
        tv[8]  = mkv(mk_in(enc_r(ADD, 5'd0, 5'd0, 5'd1), 32'hAB, 32'hCD, 0, 0, 1, 1, 0, 32'hFF),
                     0, 32'd0, 32'd0, 32'h0800, 0, 1, 1);
        tv[9]  = mkv(hlt_in, 0, 32'd0, 32'd0, 32'd0, 5, 0, 1);
        tv[10] = mkv(add_in, 1, 32'd0, 32'd0, 32'd0, 5, 0, 0);
        tv[11] = mkv(add_in, 1, 32'd0, 32'd0, 32'd0, 5, 0, 0);
        tv[12] = mkv(mk_in(add_in.ins, 32'd5, 32'd7, 0, 1, 1, 0, 0, 32'd0), 1, 32'd0, 32'd0, 32'd0, 5, 0, 0);
        tv[13] = mkv(add_in, 0, 32'd5, 32'd7, 32'h1800, 0, 3, 1);
        tv[14] = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'd1, 32'd2, 1, 0, 1, 0, 0, 32'd0),
                     0, 32'd5, 32'd7, 32'h1800, 0, 3, 1);
        tv[15] = mkv(mk_in(enc_i(LW, 5'd1, 5'd9, 16'd0), 32'd3, 32'd4, 1, 1, 1, 0, 0, 32'd0),
                     0, 32'd5, 32'd7, 32'h1800, 0, 3, 1);
        tv[16] = mkv(mk_in(add_in.ins, 32'd8, 32'd9, 1, 0, 0, 0, 0, 32'd0), 0, 32'd5, 32'd7, 32'h1800, 0, 3, 1);
        tv[17] = mkv(mk_in(enc_i(LW, 5'd1, 5'd2, 16'd0), 32'h100, 32'd0, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'h100, 32'd0, 32'd0, 2, 2, 1);
        tv[18] = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'd5, 32'd6, 0, 1, 1, 0, 0, 32'd0),
                     1, 32'h100, 32'd0, 32'd0, 2, 0, 0);
        tv[19] = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'd5, 32'd6, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'd5, 32'd6, 32'h2800, 0, 5, 1);
        tv[20] = mkv(mk_in(add_in.ins, 32'd9, 32'd8, 0, 0, 0, 0, 0, 32'd0), 0, 32'd9, 32'd8, 32'h1800, 0, 0, 0);
        tv[21] = mkv(mk_in(enc_i(LW, 5'd1, 5'd2, 16'd0), 32'h100, 32'd0, 0, 0, 1, 0, 0, 32'd0),
                     0, 32'h100, 32'd0, 32'd0, 2, 2, 1);
        tv[22] = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'd5, 32'd6, 1, 0, 1, 0, 0, 32'd0),
                     0, 32'h100, 32'd0, 32'd0, 2, 2, 1);
        tv[23] = mkv(mk_in(enc_r(SUB, 5'd2, 5'd3, 5'd5), 32'd5, 32'd6, 0, 0, 1, 0, 0, 32'd0),
                     1, 32'h100, 32'd0, 32'd0, 2, 0, 0);

        drive(mk_in(32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 32'd0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tv[i].in);
            #1;
            chk($sformatf("v%0d stall_o", i), 32'(dif.stall_o), 32'(tv[i].stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d a_o", i), dif.a_o, tv[i].a);
            chk($sformatf("v%0d b_o", i), dif.b_o, tv[i].b);
            chk($sformatf("v%0d imm_o", i), dif.imm_o, tv[i].imm);
            chk($sformatf("v%0d type_o", i), 32'(dif.type_o), 32'(tv[i].ty));
            chk($sformatf("v%0d dest_o", i), 32'(dif.dest_o), 32'(tv[i].dest));
            chk($sformatf("v%0d valid_o", i), 32'(dif.valid_o), 32'(tv[i].valid));
        end

        // Enter HALTED, then hit rst between edges: everything must clear at once.
        @(negedge clk);
        drive(hlt_in);
        @(posedge clk);
        #1;
        chk("halt type_o", 32'(dif.type_o), 32'd5);
        chk("halt valid_o", 32'(dif.valid_o), 32'd1);
        @(negedge clk);
        drive(add_in);
        #1;
        chk("halted stall_o", 32'(dif.stall_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst stall_o", 32'(dif.stall_o), 32'd0);
        chk("arst ins_o", dif.ins_o, 32'd0);
        chk("arst npc_o", dif.npc_o, 32'd0);
        chk("arst imm_o", dif.imm_o, 32'd0);
        chk("arst a_o", dif.a_o, 32'd0);
        chk("arst b_o", dif.b_o, 32'd0);
        chk("arst type_o", 32'(dif.type_o), 32'd0);
        chk("arst dest_o", 32'(dif.dest_o), 32'd0);
        chk("arst valid_o", 32'(dif.valid_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step_model(add_in);
        chk("post-rst a_o", dif.a_o, 32'd5);
        chk("post-rst b_o", dif.b_o, 32'd7);
        chk("post-rst dest_o", 32'(dif.dest_o), 32'd3);
        chk("post-rst type_o", 32'(dif.type_o), 32'd0);
        chk("post-rst valid_o", 32'(dif.valid_o), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            rx = rand_in();
            step_model(rx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
